sdr_dram_controller: RTL and testbench

Sequencing front end that sits directly upstream of the SDR single-port DRAM array. It converts a host valid/ready request stream into single-cycle Enable/Read/Write strobes and address/data drive for the array, and it captures read data. It also issues periodic Refresh bursts and gives them priority over host traffic.

---
 rtl/sdr_dram_pkg.sv | 21 ++
 rtl/sdr_dram_controller_refresh_timer.sv | 45 ++++
 rtl/sdr_dram_controller.sv | 148 ++++++++++++++
 tb/tb_sdr_dram_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_dram_pkg.sv
// Shared types and width helpers for the SDR DRAM sequencing front end.
package sdr_dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_RD_CAPTURE,
    ST_WR_STROBE,
    ST_REFRESH
  } ctrl_state_t;

  // Widths depend on per-instance parameters, so they are derived through helpers.
  function automatic int cnt_width(input int refresh_interval);
    return $clog2(refresh_interval);
  endfunction

  function automatic int burst_width(input int refresh_cycles);
    return $clog2(refresh_cycles + 1);
  endfunction

endpackage

// File: rtl/sdr_dram_controller_refresh_timer.sv
// Free-running refresh interval counter; raises pending at each expiry and
// flags a sticky error when an expiry finds the previous refresh still pending.
module sdr_refresh_timer
  import sdr_dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_refresh_start,
  output logic o_pending,
  output logic o_refresh_missed
);

  localparam int CNT_W = cnt_width(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_missed;
  logic             w_expire;

  assign w_expire = (r_cnt == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      r_cnt <= w_expire ? RELOAD : r_cnt - CNT_W'(1);
      // Expiry wins over an acknowledge on the same edge so no request is lost.
      if (w_expire)
        r_pending <= 1'b1;
      else if (i_refresh_start)
        r_pending <= 1'b0;
      if (w_expire && r_pending)
        r_missed <= 1'b1;
    end
  end

  assign o_pending        = r_pending;
  assign o_refresh_missed = r_missed;

endmodule

// File: rtl/sdr_dram_controller.sv
// Turns a host valid/ready stream into registered Enable/Read/Write strobes for
// the SDR array, captures read data, and inserts prioritised refresh bursts.
module sdr_dram_controller
  import sdr_dram_pkg::*;
#(
  parameter int ADDR_WIDTH       = 1,
  parameter int DATA_WIDTH       = 1,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWData,
  output logic                  RdValid,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  Enable,
  output logic                  Read,
  output logic                  Write,
  output logic                  Refresh,
  output logic [DATA_WIDTH-1:0] MemDataOut,
  output logic                  MemDataOe,
  input  logic [DATA_WIDTH-1:0] MemDataIn,
  output logic                  RefreshMissed
);

  localparam int BURST_W = burst_width(REFRESH_CYCLES);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(REFRESH_CYCLES - 1);

  ctrl_state_t           r_state;
  logic                  r_live;
  logic [BURST_W-1:0]    r_burst;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_enable, r_read, r_write, r_refresh, r_oe, r_rd_valid;
  logic                  w_pending;
  logic                  w_refresh_missed;
  logic                  w_refresh_start;

  sdr_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .Clock           (Clock),
    .Reset           (Reset),
    .i_refresh_start (w_refresh_start),
    .o_pending       (w_pending),
    .o_refresh_missed(w_refresh_missed)
  );

  // A pending refresh is taken from IDLE, or chained directly at the end of a burst.
  assign w_refresh_start = w_pending &&
                           ((r_state == ST_IDLE) || (r_state == ST_REFRESH && r_burst == '0));

  // r_live keeps ReqReady low while Reset is held.
  assign ReqReady = r_live && (r_state == ST_IDLE) && !w_pending;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_live     <= 1'b0;
      r_burst    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_enable   <= 1'b0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_refresh  <= 1'b0;
      r_oe       <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state   <= ST_REFRESH;
            r_refresh <= 1'b1;
            r_burst   <= BURST_LAST;
          end else if (ReqValid && r_live) begin
            r_addr   <= ReqAddr;
            r_enable <= 1'b1;
            if (ReqWrite) begin
              r_wdata <= ReqWData;
              r_write <= 1'b1;
              r_oe    <= 1'b1;
              r_state <= ST_WR_STROBE;
            end else begin
              r_read  <= 1'b1;
              r_state <= ST_RD_STROBE;
            end
          end
        end
        ST_WR_STROBE: begin
          r_enable <= 1'b0;
          r_write  <= 1'b0;
          r_oe     <= 1'b0;
          r_state  <= ST_IDLE;
        end
        ST_RD_STROBE: begin
          r_enable <= 1'b0;
          r_read   <= 1'b0;
          r_state  <= ST_RD_CAPTURE;
        end
        ST_RD_CAPTURE: begin
          r_rdata    <= MemDataIn;
          r_rd_valid <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_REFRESH: begin
          if (r_burst != '0) begin
            r_burst <= r_burst - BURST_W'(1);
          end else if (w_pending) begin
            r_burst <= BURST_LAST;
          end else begin
            r_refresh <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_enable  <= 1'b0;
          r_read    <= 1'b0;
          r_write   <= 1'b0;
          r_oe      <= 1'b0;
          r_refresh <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign Address       = r_addr;
  assign Enable        = r_enable;
  assign Read          = r_read;
  assign Write         = r_write;
  assign Refresh       = r_refresh;
  assign MemDataOut    = r_wdata;
  assign MemDataOe     = r_oe;
  assign RdValid       = r_rd_valid;
  assign RdData        = r_rdata;
  assign RefreshMissed = w_refresh_missed;

endmodule

// File: tb/tb_sdr_dram_controller.sv
// Directed bench for sdr_dram_controller with a small behavioural array model.
module tb_sdr_dram_controller;

  logic       Clock;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic       ReqWrite;
  logic [3:0] ReqAddr;
  logic [7:0] ReqWData;
  logic       RdValid;
  logic [7:0] RdData;
  logic [3:0] Address;
  logic       Enable;
  logic       Read;
  logic       Write;
  logic       Refresh;
  logic [7:0] MemDataOut;
  logic       MemDataOe;
  logic [7:0] MemDataIn;
  logic       RefreshMissed;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [16];
  logic       mem_clear;

  sdr_dram_controller #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .REFRESH_INTERVAL(16), .REFRESH_CYCLES(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RdValid(RdValid), .RdData(RdData), .Address(Address), .Enable(Enable),
    .Read(Read), .Write(Write), .Refresh(Refresh), .MemDataOut(MemDataOut),
    .MemDataOe(MemDataOe), .MemDataIn(MemDataIn), .RefreshMissed(RefreshMissed)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Array model: word i powers up as {i, ~i}; writes land on the strobe edge.
  always @(posedge Clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4'(i), ~4'(i)};
    end else if (Enable && Write) begin
      mem[Address] <= MemDataOut;
    end
  end
  assign MemDataIn = mem[Address];

  function automatic logic [7:0] exp_word(input int k);
    logic [3:0] a;
    a = k[3:0];
    return (a == 4'h5) ? 8'hA7 : {a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    Reset    = 1'b1;
    ReqValid = 1'b0;
    #1;
    chk("rst_ctrl", {Enable, Read, Write, Refresh, MemDataOe, RdValid, ReqReady, RefreshMissed}, 0);
    chk("rst_bus", {Address, MemDataOut, RdData}, 0);
    @(posedge Clock);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cyc   = 0;
  endtask

  logic took;
  int   nxt, nrd;

  initial begin
    Reset     = 1'b0;
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    ReqAddr   = 4'h0;
    ReqWData  = 8'h00;
    mem_clear = 1'b1;
    #2;

    // 1: write 0x5/0xA7 then read it back
    apply_reset();
    mem_clear = 1'b0;
    chk("rdy_after_release", ReqReady, 0);
    step();
    chk("rdy_idle", ReqReady, 1);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'h5; ReqWData = 8'hA7;
    step();
    ReqValid = 1'b0;
    chk("wr_strobe", {Enable, Write, Read, MemDataOe}, 4'b1101);
    chk("wr_addr", Address, 4'h5);
    chk("wr_data", MemDataOut, 8'hA7);
    step();
    chk("wr_done", {Enable, Write, MemDataOe}, 0);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'h5;
    step();
    ReqValid = 1'b0;
    chk("rd_strobe", {Enable, Read, Write, MemDataOe}, 4'b1100);
    chk("rd_addr", Address, 4'h5);
    step();
    chk("rd_capture", {Enable, Read, RdValid}, 0);
    step();
    chk("rd_valid", RdValid, 1);
    chk("rd_data", RdData, 8'hA7);
    step();
    chk("rd_valid_pulse", RdValid, 0);
    chk("rd_data_held", RdData, 8'hA7);

    // 2: refresh cadence with no traffic
    apply_reset();
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("ref_cadence", Refresh, (k >= 17) && ((k % 16 == 1) || (k % 16 == 2)));
      chk("ref_no_enable", Enable, 0);
    end
    chk("ref_no_miss", RefreshMissed, 0);

    // 3: request accepted on the expiry edge, refresh follows, next request waits
    apply_reset();
    ReqWrite = 1'b0; ReqAddr = 4'h3;
    repeat (15) step();
    chk("col_rdy_before", ReqReady, 1);
    ReqValid = 1'b1;
    step();
    chk("col_rd_strobe", {Read, Address}, {1'b1, 4'h3});
    chk("col_rdy_busy", ReqReady, 0);
    ReqAddr = 4'h4;
    step();
    chk("col_capture", {Read, Refresh}, 0);
    step();
    chk("col_rd_valid", {RdValid, RdData}, {1'b1, 8'h3C});
    chk("col_rdy_pending", ReqReady, 0);
    step();
    chk("col_ref1", {Refresh, Enable, ReqReady}, 3'b100);
    step();
    chk("col_ref2", {Refresh, Read, ReqReady}, 3'b100);
    step();
    chk("col_ref_end", {Refresh, Read, ReqReady}, 3'b001);
    step();
    chk("col_next_strobe", {Read, Address}, {1'b1, 4'h4});
    ReqValid = 1'b0;
    step();
    step();
    chk("col_next_data", {RdValid, RdData}, {1'b1, 8'h4B});

    // 4: reset asserted during the read strobe
    apply_reset();
    step();
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'h7;
    step();
    chk("rr_strobe", Read, 1);
    apply_reset();
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("rr_no_rdvalid", RdValid, 0);
      chk("rr_refresh", Refresh, k == 17);
    end

    // 5: back-to-back reads of every address
    apply_reset();
    ReqWrite = 1'b0; ReqAddr = 4'h0; ReqValid = 1'b1;
    nxt = 0; nrd = 0;
    for (int s = 0; s < 300 && nrd < 16; s++) begin
      took = ReqValid && ReqReady;
      step();
      if (took) begin
        nxt++;
        if (nxt == 16) ReqValid = 1'b0;
        else ReqAddr = nxt[3:0];
      end
      chk("sat_rw_excl", Read && Write, 0);
      chk("sat_en_ref", Enable && Refresh, 0);
      if (RdValid) begin
        chk("sat_rddata", RdData, exp_word(nrd));
        nrd++;
      end
    end
    ReqValid = 1'b0;
    chk("sat_count", nrd, 16);
    step();
    chk("sat_no_extra", RdValid, 0);

    // 6: refresh acknowledge held off so the second expiry finds pending set
    apply_reset();
    force dut.w_refresh_start = 1'b0;
    repeat (31) step();
    chk("miss_before", RefreshMissed, 0);
    step();
    chk("miss_set", RefreshMissed, 1);
    release dut.w_refresh_start;
    repeat (40) step();
    chk("miss_sticky", RefreshMissed, 1);
    Reset = 1'b1;
    #1;
    chk("miss_cleared", RefreshMissed, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
